// File: rtl/serial_parallel_sr.sv
// Serial-to-parallel shift register (MSB first) with a double-buffered output word.
// Optional even-parity bit per frame when SERIAL_PARALLEL_PARITY_EN is defined.
module serial_parallel_sr #(
    parameter int INPUT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   data_in,
    input  logic                   bit_valid,
    input  logic                   frame_start,
    output logic [INPUT_WIDTH-1:0] data_out,
    output logic                   data_valid,
    input  logic                   data_ready,
    output logic                   overrun,
    output logic                   parity_err,
    output logic                   fsm_state
);

`ifdef SERIAL_PARALLEL_PARITY_EN
    localparam int FRAME_LEN = INPUT_WIDTH + 1;
`else
    localparam int FRAME_LEN = INPUT_WIDTH;
`endif
    // All frame bits except the last are held here; the last one is used straight from data_in.
    localparam int SR_W = FRAME_LEN - 1;
    localparam int CW   = $clog2(FRAME_LEN + 1);

    // Handshake: a word transfers on any edge where data_valid && data_ready;
    // data_out is frozen while data_valid is high and not yet accepted.
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t                 state, state_nx;
    logic [CW-1:0]          count, count_nx;
    logic [SR_W-1:0]        sr, sr_nx;
    logic                   complete;
    logic [INPUT_WIDTH-1:0] word;
    logic                   word_perr;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            sr    <= '0;
        end else begin
            state <= state_nx;
            count <= count_nx;
            sr    <= sr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        count_nx = count;
        sr_nx    = sr;
        complete = 1'b0;
`ifdef SERIAL_PARALLEL_PARITY_EN
        word      = sr;
        word_perr = ^{sr, data_in};
`else
        word      = {sr, data_in};
        word_perr = 1'b0;
`endif
        if (bit_valid) begin
            // frame_start always restarts, even over a frame that would complete now.
            if (frame_start) begin
                state_nx = SHIFT;
                count_nx = CW'(1);
                sr_nx    = SR_W'(data_in);
            end else if (state == SHIFT) begin
                if (count == CW'(FRAME_LEN - 1)) begin
                    complete = 1'b1;
                    state_nx = IDLE;
                    count_nx = '0;
                    sr_nx    = '0;
                end else begin
                    count_nx = count + CW'(1);
                    sr_nx    = SR_W'({sr, data_in});
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (complete && (!data_valid || data_ready)) begin
                data_out   <= word;
                data_valid <= 1'b1;
                parity_err <= word_perr;
            end else if (complete) begin
                overrun <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_serial_parallel_sr.sv
// Self-checking bench for serial_parallel_sr: scenario tasks plus an output monitor
// that pops expected {parity_err, data_out} words from a queue whenever a word loads.
module tb_serial_parallel_sr;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         data_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         frame_start = 1'b0;
    logic         data_ready = 1'b1;
    logic [W-1:0] data_out;
    logic         data_valid;
    logic         overrun;
    logic         parity_err;
    logic         fsm_state;

    int n_cmp = 0;
    int n_err = 0;
    int ov_cnt = 0;

    logic [W:0]   exp_q[$];
    logic [W:0]   exp_w;
    logic         prev_valid = 1'b0;
    logic         prev_ready = 1'b0;
    logic [W-1:0] prev_out = '0;

    serial_parallel_sr #(.INPUT_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .data_in(data_in), .bit_valid(bit_valid),
        .frame_start(frame_start), .data_out(data_out), .data_valid(data_valid),
        .data_ready(data_ready), .overrun(overrun), .parity_err(parity_err),
        .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    // Output monitor: a new word is present when valid rises or was just accepted.
    always @(negedge clk) begin
        if (overrun) ov_cnt++;
        if (reset) begin
            prev_valid = 1'b0;
        end else begin
            if (data_valid && (!prev_valid || prev_ready)) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_word: got %h, expected no word", data_out);
                end else begin
                    exp_w = exp_q.pop_front();
                    if ({parity_err, data_out} !== exp_w) begin
                        n_err++;
                        $display("FAIL word: got perr=%b data=%h, expected perr=%b data=%h",
                                 parity_err, data_out, exp_w[W], exp_w[W-1:0]);
                    end
                end
            end else if (data_valid && prev_valid && !prev_ready) begin
                n_cmp++;
                if (data_out !== prev_out) begin
                    n_err++;
                    $display("FAIL hold_stable: got %h, expected %h", data_out, prev_out);
                end
            end
            prev_valid = data_valid;
        end
        prev_ready = data_ready;
        prev_out   = data_out;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic fs);
        bit_valid   = 1'b1;
        data_in     = b;
        frame_start = fs;
        tick();
        bit_valid   = 1'b0;
        frame_start = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // Sends one frame; if push, queues the word the DUT should present.
    task automatic send_frame(input logic [W-1:0] w, input int gap, input bit push, input logic par);
        logic perr;
`ifdef SERIAL_PARALLEL_PARITY_EN
        perr = (^w) ^ par;
`else
        perr = 1'b0;
`endif
        if (push) exp_q.push_back({perr, w});
        for (int i = W - 1; i >= 0; i--) begin
            send_bit(w[i], i == W - 1);
            if (gap > 0 && i > 0) idle(gap);
        end
`ifdef SERIAL_PARALLEL_PARITY_EN
        if (gap > 0) idle(gap);
        send_bit(par, 1'b0);
`endif
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        n_cmp++;
        if ({data_out, data_valid, overrun, parity_err, fsm_state} !== {{W{1'b0}}, 4'b0000}) begin
            n_err++;
            $display("FAIL reset_state: got out=%h v=%b ov=%b pe=%b st=%b, expected all 0",
                     data_out, data_valid, overrun, parity_err, fsm_state);
        end
    endtask

    task automatic test_basic();
        reset = 1'b0;
        data_ready = 1'b1;
        send_frame(8'hAA, 0, 1'b1, 1'b0);
        n_cmp++;
        if (data_valid !== 1'b1 || data_out !== 8'hAA) begin
            n_err++;
            $display("FAIL basic_latency: got v=%b out=%h, expected v=1 out=aa", data_valid, data_out);
        end
        tick();
        n_cmp++;
        if (data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_accept: got v=%b, expected 0", data_valid);
        end
    endtask

    task automatic test_gaps();
        send_frame(8'hCC, 1, 1'b1, 1'b0);
        n_cmp++;
        if (data_valid !== 1'b1 || data_out !== 8'hCC) begin
            n_err++;
            $display("FAIL gaps_word: got v=%b out=%h, expected v=1 out=cc", data_valid, data_out);
        end
        // Stray bits without frame_start in IDLE must not build a word.
        for (int k = 0; k < 2 * W + 2; k++) send_bit(1'b1, 1'b0);
        idle(2);
        n_cmp++;
        if (data_valid !== 1'b0 || fsm_state !== 1'b0) begin
            n_err++;
            $display("FAIL idle_ignore: got v=%b st=%b, expected v=0 st=0", data_valid, fsm_state);
        end
    endtask

    task automatic test_overrun();
        int ov0;
        data_ready = 1'b0;
        send_frame(8'hAA, 0, 1'b1, 1'b0);
        ov0 = ov_cnt;
        send_frame(8'h55, 0, 1'b0, 1'b1);
        n_cmp++;
        if (overrun !== 1'b1 || data_out !== 8'hAA || data_valid !== 1'b1) begin
            n_err++;
            $display("FAIL overrun_pulse: got ov=%b out=%h v=%b, expected ov=1 out=aa v=1",
                     overrun, data_out, data_valid);
        end
        tick();
        n_cmp++;
        if (overrun !== 1'b0 || data_out !== 8'hAA) begin
            n_err++;
            $display("FAIL overrun_one_cycle: got ov=%b out=%h, expected ov=0 out=aa", overrun, data_out);
        end
        n_cmp++;
        if (ov_cnt != ov0 + 1) begin
            n_err++;
            $display("FAIL overrun_count: got %0d, expected %0d", ov_cnt - ov0, 1);
        end
        data_ready = 1'b1;
        tick();
        n_cmp++;
        if (data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL overrun_drain: got v=%b, expected 0", data_valid);
        end
    endtask

    task automatic test_restart();
        int ov0;
        ov0 = ov_cnt;
        for (int k = 0; k < 5; k++) send_bit(1'b1, k == 0);
        send_frame(8'h3C, 0, 1'b1, 1'b0);
        n_cmp++;
        if (data_out !== 8'h3C || data_valid !== 1'b1) begin
            n_err++;
            $display("FAIL restart_word: got out=%h v=%b, expected out=3c v=1", data_out, data_valid);
        end
        tick();
        n_cmp++;
        if (ov_cnt != ov0) begin
            n_err++;
            $display("FAIL restart_no_overrun: got %0d pulses, expected 0", ov_cnt - ov0);
        end
    endtask

    task automatic test_reset_mid();
        int ov0;
        data_ready = 1'b0;
        send_frame(8'h5A, 0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) send_bit(k[0], k == 0);
        ov0 = ov_cnt;
        reset = 1'b1;
        tick();
        n_cmp++;
        if (data_valid !== 1'b0 || data_out !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid: got v=%b out=%h, expected v=0 out=00", data_valid, data_out);
        end
        tick();
        reset = 1'b0;
        data_ready = 1'b1;
        send_frame(8'hF0, 0, 1'b1, 1'b0);
        n_cmp++;
        if (data_out !== 8'hF0 || data_valid !== 1'b1 || ov_cnt != ov0) begin
            n_err++;
            $display("FAIL reset_then_frame: got out=%h v=%b ov=%0d, expected out=f0 v=1 ov=0",
                     data_out, data_valid, ov_cnt - ov0);
        end
        tick();
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        for (int n = 0; n < 8; n++) begin
            w = W'($urandom_range(0, 255));
            send_frame(w, $urandom_range(0, 2), 1'b1, ^w);
            idle($urandom_range(1, 3));
        end
    endtask

`ifdef SERIAL_PARALLEL_PARITY_EN
    task automatic test_parity();
        send_frame(8'h01, 0, 1'b1, 1'b0);
        n_cmp++;
        if (parity_err !== 1'b1) begin
            n_err++;
            $display("FAIL parity_bad: got %b, expected 1", parity_err);
        end
        tick();
        send_frame(8'h01, 0, 1'b1, 1'b1);
        n_cmp++;
        if (parity_err !== 1'b0) begin
            n_err++;
            $display("FAIL parity_good: got %b, expected 0", parity_err);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_overrun();
        test_restart();
        test_reset_mid();
        test_random();
`ifdef SERIAL_PARALLEL_PARITY_EN
        test_parity();
`endif
        idle(3);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL missing_words: got %0d words outstanding, expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
